burst_shift_reg: RTL and testbench
==================================

# burst_shift_reg

Parametrised universal shift register with single-step and multi-step (burst) modes. In idle it applies one operation per clock: hold, load, logical shift, rotate or arithmetic shift. A start strobe launches a counted burst of N identical shift steps, with busy/done handshake outputs. It is the general-purpose successor to the fixed 8-bit, 4-mode shift register and serves any datapath needing serialisation or barrel-style shifting over several cycles.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), width of the burst amount field (derived; do not override)

- clk  input  1  rising-edge clock; the single clock domain
- reset  input  1  synchronous, active-low reset (one clock, reset active low, synchronous)
- mode  input  3  operation select: 0 hold, 1 load, 2 shl, 3 shr, 4 rotl, 5 rotr, 6 sar, 7 hold (reserved)
- start  input  1  launches a burst of `amount` steps of `mode`
- amount  input  CNT_W  burst step count, 0..2^CNT_W-1
- data_in  input  WIDTH  parallel load value
- serial_in  input  1  fill bit for shl (into LSB) and shr (into MSB)
- data_out  output  WIDTH  register contents
- serial_out  output  1  bit ejected by the most recent shift/rotate step
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at burst completion

## Operation
- Two states: IDLE and RUN.
- Step definitions, with register Q:
  - shl: Q <= {Q[W-2:0], serial_in}; ejects Q[W-1].
  - shr: Q <= {serial_in, Q[W-1:1]}; ejects Q[0].
  - rotl: Q <= {Q[W-2:0], Q[W-1]}; ejects Q[W-1].
  - rotr: Q <= {Q[0], Q[W-1:1]}; ejects Q[0].
  - sar: Q <= {Q[W-1], Q[W-1:1]}; ejects Q[0].
- IDLE, start=0: apply mode for one step each edge.
  - load: Q <= data_in.
  - hold/7: Q unchanged.
  - serial_out updates only on a shift or rotate step; otherwise it holds.
- IDLE, start=1, mode in 2..6:
  - Latch mode into op_r and amount into cnt; Q is unchanged on this edge.
  - If amount≠0, go to RUN.
  - If amount=0, stay in IDLE and assert done for the next cycle.
- IDLE, start=1, mode in 0, 1 or 7: start is ignored and the mode applies as a single step.
- RUN: each edge performs one op_r step and decrements cnt. The edge that takes cnt from 1 to 0 performs the final step, returns to IDLE and sets done.
  - serial_in is sampled live on every RUN step.
  - mode, start, amount and data_in are ignored while busy=1.
- done is high for exactly one cycle, then clears automatically.
- Counter arithmetic is unsigned CNT_W-bit; cnt never underflows. Amounts greater than WIDTH are legal and perform that many steps. For example, rotl by WIDTH restores Q.

## Timing
- Reset (reset=0 at an edge):
  - data_out=0, serial_out=0, busy=0, done=0, cnt=0, state=IDLE.
  - Reset wins over every other input and aborts any burst mid-flight; no done is issued for the aborted burst.
- Single-step ops take effect at the edge that samples them (1-cycle latency to data_out).
- Burst of N≥1 accepted at edge k:
  - Shifts occur at edges k+1 .. k+N.
  - busy=1 from after edge k until edge k+N.
  - done=1 for the cycle between edges k+N and k+N+1.
  - data_out is final while done=1.
- A new start is accepted in the same cycle that done=1, since the block is already in IDLE. This allows back-to-back bursts with no gap.
- Burst of N=0: busy stays 0, done=1 for the cycle after edge k, Q is unchanged.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset: hold reset=0 for 2 edges with random inputs, including start=1 → data_out=0x00, serial_out=0, busy=0, done=0.
- Single steps, WIDTH=8:
  - load 0x64.
  - mode=2 with serial_in=0 → 0xC8, serial_out=0.
  - mode=3 with serial_in=1 → 0xE4, serial_out=0.
  - mode=0 for 3 cycles → stays 0xE4.
- rotl burst: load 0x81, then start with mode=4, amount=3 → busy high for exactly 3 cycles, Q steps 0x03, 0x06, 0x0C, done pulses once with data_out=0x0C.
- sar burst: load 0x90, then start with mode=6, amount=2 → 0xC8 then 0xE4, serial_out=0, done one cycle.
- Zero amount and busy-time inputs:
  - start with amount=0 → busy never asserts, done=1 for one cycle, Q unchanged.
  - During a 5-step shl burst, drive start=1, mode=1, data_in=0xFF → all ignored; the burst completes with the expected value.
  - Back-to-back: a start issued in the done cycle is accepted.
- Reset mid-burst: start rotr with amount=6; assert reset=0 after 2 steps → next cycle all outputs are 0 and no done pulse occurs. A fresh start immediately after reset deasserts is accepted.

Source files
------------

// File: rtl/burst_shift_reg.sv
// Universal shift register: one hold/load/shift/rotate/sar step per clock in idle,
// or a counted burst of identical shift steps launched by start, with busy/done handshake.
module burst_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] ModeLoad = 3'd1;
  localparam logic [2:0] ModeShl  = 3'd2;
  localparam logic [2:0] ModeShr  = 3'd3;
  localparam logic [2:0] ModeRotl = 3'd4;
  localparam logic [2:0] ModeRotr = 3'd5;
  localparam logic [2:0] ModeSar  = 3'd6;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [2:0]       op_sel;
  logic             op_is_shift;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  // Step datapath shared by idle single steps and burst steps.
  always_comb begin
    op_sel      = (state_q == StRun) ? op_q : mode;
    op_is_shift = (op_sel >= ModeShl) && (op_sel <= ModeSar);
    step_val    = q_q;
    step_bit    = sout_q;
    case (op_sel)
      ModeShl: begin
        step_val = {q_q[WIDTH-2:0], serial_in};
        step_bit = q_q[WIDTH-1];
      end
      ModeShr: begin
        step_val = {serial_in, q_q[WIDTH-1:1]};
        step_bit = q_q[0];
      end
      ModeRotl: begin
        step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        step_bit = q_q[WIDTH-1];
      end
      ModeRotr: begin
        step_val = {q_q[0], q_q[WIDTH-1:1]};
        step_bit = q_q[0];
      end
      ModeSar: begin
        step_val = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        step_bit = q_q[0];
      end
      default: begin
        step_val = q_q;
        step_bit = sout_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == StRun) begin
      q_d    = step_val;
      sout_d = step_bit;
      cnt_d  = cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end else if (start && op_is_shift) begin
      // Accept edge only latches the burst; the first step happens on the next edge.
      op_d  = mode;
      cnt_d = amount;
      if (amount != '0) begin
        state_d = StRun;
      end else begin
        done_d = 1'b1;
      end
    end else if (mode == ModeLoad) begin
      q_d = data_in;
    end else if (op_is_shift) begin
      q_d    = step_val;
      sout_d = step_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      sout_q  <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign data_out   = q_q;
  assign serial_out = sout_q;
  assign busy       = (state_q == StRun);
  assign done       = done_q;

endmodule

// File: tb/tb_burst_shift_reg.sv
// Bench for burst_shift_reg: directed vector table followed by randomized traffic
// checked against an arithmetic reference model.
module tb_burst_shift_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    mode;
  logic          start;
  logic [CW-1:0] amount;
  logic [W-1:0]  data_in;
  logic          serial_in;
  logic [W-1:0]  data_out;
  logic          serial_out;
  logic          busy;
  logic          done;

  burst_shift_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .start     (start),
    .amount    (amount),
    .data_in   (data_in),
    .serial_in (serial_in),
    .data_out  (data_out),
    .serial_out(serial_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the register value plus a remaining-steps count.
  logic [W-1:0] m_q;
  logic         m_sout;
  logic         m_busy;
  logic         m_done;
  int           m_rem;
  int           m_op;

  function automatic logic [W-1:0] do_step(input int op, input logic [W-1:0] q, input logic sin,
                                           output logic ej);
    logic [W-1:0] r;
    case (op)
      2: begin r = W'((q << 1) | W'(sin));              ej = q[W-1]; end
      3: begin r = W'((q >> 1) | (W'(sin) << (W - 1))); ej = q[0];   end
      4: begin r = W'((q << 1) | (q >> (W - 1)));       ej = q[W-1]; end
      5: begin r = W'((q >> 1) | (q << (W - 1)));       ej = q[0];   end
      default: begin r = W'($signed(q) >>> 1);          ej = q[0];   end
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    logic ej;
    if (!reset) begin
      m_q = '0; m_sout = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_op = 0;
    end else if (m_busy) begin
      m_q    = do_step(m_op, m_q, serial_in, ej);
      m_sout = ej;
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
      m_busy = (m_rem != 0);
    end else begin
      m_done = 1'b0;
      if (start && mode >= 2 && mode <= 6) begin
        m_op  = int'(mode);
        m_rem = int'(amount);
        if (m_rem == 0) m_done = 1'b1;
        else            m_busy = 1'b1;
      end else if (mode == 1) begin
        m_q = data_in;
      end else if (mode >= 2 && mode <= 6) begin
        m_q    = do_step(int'(mode), m_q, serial_in, ej);
        m_sout = ej;
      end
    end
  end

  typedef struct {
    logic         rst_n;
    logic [2:0]   mode;
    logic         start;
    int           amt;
    logic [W-1:0] din;
    logic         sin;
    logic [W-1:0] exp_q;
    logic         exp_so;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] md, input logic st, input int am,
                     input logic [W-1:0] di, input logic si, input logic [W-1:0] eq,
                     input logic eso, input logic eb, input logic ed);
    vec_t v;
    v.rst_n = r; v.mode = md; v.start = st; v.amt = am; v.din = di; v.sin = si;
    v.exp_q = eq; v.exp_so = eso; v.exp_busy = eb; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset with noisy inputs
    add(0, 4, 1, 3, 8'hA5, 1, 8'h00, 0, 0, 0);
    add(0, 2, 1, 5, 8'hFF, 1, 8'h00, 0, 0, 0);
    // Single steps
    add(1, 1, 0, 0, 8'h64, 0, 8'h64, 0, 0, 0);
    add(1, 2, 0, 0, 8'h00, 0, 8'hC8, 0, 0, 0);
    add(1, 3, 0, 0, 8'h00, 1, 8'hE4, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 1, 8'hE4, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 1, 8'hE4, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 1, 8'hE4, 0, 0, 0);
    // rotl burst of 3
    add(1, 1, 0, 0, 8'h81, 0, 8'h81, 0, 0, 0);
    add(1, 4, 1, 3, 8'h00, 0, 8'h81, 0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 8'h03, 1, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 8'h06, 0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 8'h0C, 0, 0, 1);
    add(1, 0, 0, 0, 8'h00, 0, 8'h0C, 0, 0, 0);
    // sar burst of 2
    add(1, 1, 0, 0, 8'h90, 0, 8'h90, 0, 0, 0);
    add(1, 6, 1, 2, 8'h00, 0, 8'h90, 0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 8'hC8, 0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 8'hE4, 0, 0, 1);
    add(1, 0, 0, 0, 8'h00, 0, 8'hE4, 0, 0, 0);
    // Zero-amount burst
    add(1, 2, 1, 0, 8'h00, 0, 8'hE4, 0, 0, 1);
    add(1, 0, 0, 0, 8'h00, 0, 8'hE4, 0, 0, 0);
    // shl burst of 5 with busy-time noise, then back-to-back rotr by 1 in the done cycle
    add(1, 2, 1, 5, 8'h00, 1, 8'hE4, 0, 1, 0);
    add(1, 1, 1, 3, 8'hFF, 1, 8'hC9, 1, 1, 0);
    add(1, 1, 1, 3, 8'hFF, 1, 8'h93, 1, 1, 0);
    add(1, 1, 1, 3, 8'hFF, 1, 8'h27, 1, 1, 0);
    add(1, 1, 1, 3, 8'hFF, 1, 8'h4F, 0, 1, 0);
    add(1, 1, 1, 3, 8'hFF, 1, 8'h9F, 0, 0, 1);
    add(1, 5, 1, 1, 8'h00, 0, 8'h9F, 0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 8'hCF, 1, 0, 1);
    // Reset aborts a rotr burst; fresh start right after
    add(1, 5, 1, 6, 8'h00, 0, 8'hCF, 1, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 8'hE7, 1, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 8'hF3, 1, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(1, 4, 1, 2, 8'h00, 0, 8'h00, 0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);

    reset = 1'b0; mode = '0; start = 1'b0; amount = '0; data_in = '0; serial_in = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rst_n;
      mode      = vecs[i].mode;
      start     = vecs[i].start;
      amount    = CW'(vecs[i].amt);
      data_in   = vecs[i].din;
      serial_in = vecs[i].sin;
      @(negedge clk);
      check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d serial_out", i), 32'(serial_out), 32'(vecs[i].exp_so));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 63) != 0);
      mode      = 3'($urandom_range(0, 7));
      start     = ($urandom_range(0, 3) == 0);
      amount    = CW'($urandom_range(0, (1 << CW) - 1));
      data_in   = W'($urandom);
      serial_in = 1'($urandom);
      @(negedge clk);
      check($sformatf("rnd%0d data_out", i), 32'(data_out), 32'(m_q));
      check($sformatf("rnd%0d serial_out", i), 32'(serial_out), 32'(m_sout));
      check($sformatf("rnd%0d busy", i), 32'(busy), 32'(m_busy));
      check($sformatf("rnd%0d done", i), 32'(done), 32'(m_done));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
